// File: rtl/fetch_align_pkg.sv
// Shared types and constants for the fetch aligner and its icache handshake.
// Line-request/response structs are sized by the core-wide XLEN and line width.
package fetch_align_pkg;

  localparam int TC_XLEN     = 32;
  localparam int TC_BLK_SIZE = 128;

  // Low two bits of a halfword that mark the start of a 32-bit instruction.
  localparam logic [1:0] RVC_OPC_FULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2
  } fetch_align_state_e;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [TC_XLEN-1:0] addr;
    logic               uncached;
  } icache_req_t;

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [TC_BLK_SIZE-1:0] blk;
  } icache_res_t;

  function automatic logic is_full(input logic [15:0] hw);
    return hw[1:0] == RVC_OPC_FULL;
  endfunction

endpackage

// File: rtl/fetch_linebuf.sv
// One-line instruction buffer: line tag, valid bit, hit compare and the two
// halfwords starting at the looked-up index.
module fetch_linebuf #(
  parameter int LINE_W   = 28,
  parameter int BLK_SIZE = 128,
  parameter int HW_IDX_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load,
  input  logic                clear,
  input  logic [LINE_W-1:0]   load_line,
  input  logic [BLK_SIZE-1:0] load_blk,
  input  logic [LINE_W-1:0]   lookup_line,
  input  logic [HW_IDX_W-1:0] lookup_idx,
  output logic                hit,
  output logic [15:0]         hw_lo,
  output logic [15:0]         hw_hi
);

  logic                buf_valid;
  logic [LINE_W-1:0]   buf_line;
  logic [BLK_SIZE-1:0] buf_data;
  logic [HW_IDX_W-1:0] idx_hi;

  // Clear has priority so an invalidate racing a fill leaves the buffer empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) begin
      buf_line <= load_line;
      buf_data <= load_blk;
    end
  end

  assign idx_hi = lookup_idx + HW_IDX_W'(1);
  assign hit    = buf_valid && (lookup_line == buf_line);
  assign hw_lo  = buf_data[{lookup_idx, 4'b0000} +: 16];
  assign hw_hi  = buf_data[{idx_hi, 4'b0000} +: 16];

endmodule

// File: rtl/fetch_align.sv
// Fetch-side aligner: turns one PC into one aligned 16/32-bit instruction,
// serving from a one-line buffer or fetching one or two lines from icache.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter int XLEN     = TC_XLEN,
  parameter int BLK_SIZE = TC_BLK_SIZE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            fetch_uncached_i,
  input  logic            flush_i,
  input  logic            buf_inv_i,
  output icache_req_t     icache_req_o,
  input  icache_res_t     icache_res_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_comp_o
);

  localparam int BOFFSET  = $clog2(BLK_SIZE / 8);
  localparam int NUM_HW   = BLK_SIZE / 16;
  localparam int HW_IDX_W = BOFFSET - 1;
  localparam int LINE_W   = XLEN - BOFFSET;
  localparam logic [HW_IDX_W-1:0] LAST_HW = HW_IDX_W'(NUM_HW - 1);

  function automatic logic [15:0] hw_sel(input logic [BLK_SIZE-1:0] blk,
                                         input logic [HW_IDX_W-1:0] idx);
    return blk[{idx, 4'b0000} +: 16];
  endfunction

  fetch_align_state_e  state;
  icache_req_t         req_q;
  logic [XLEN-1:0]     pc_q;
  logic [15:0]         saved_lo;

  logic [XLEN-1:0]     pc_in;
  logic [LINE_W-1:0]   in_line;
  logic [LINE_W-1:0]   in_next;
  logic [LINE_W-1:0]   q_line;
  logic [LINE_W-1:0]   q_next;
  logic [HW_IDX_W-1:0] in_idx;
  logic [HW_IDX_W-1:0] q_idx;
  logic [HW_IDX_W-1:0] q_idx_hi;
  logic                buf_hit;
  logic [15:0]         buf_lo;
  logic [15:0]         buf_hi;
  logic                in_full;
  logic                in_strad;
  logic [15:0]         res_lo;
  logic [15:0]         res_hi;
  logic                res_full;
  logic                res_strad;
  logic                res_fire;
  logic                buf_load;
  logic                buf_clear;
  logic                unused_bits;

  assign pc_in    = {fetch_pc_i[XLEN-1:1], 1'b0};
  assign in_line  = pc_in[XLEN-1:BOFFSET];
  assign in_idx   = pc_in[BOFFSET-1:1];
  assign in_next  = in_line + LINE_W'(1);
  assign q_line   = pc_q[XLEN-1:BOFFSET];
  assign q_idx    = pc_q[BOFFSET-1:1];
  assign q_next   = q_line + LINE_W'(1);
  assign q_idx_hi = q_idx + HW_IDX_W'(1);

  assign in_full  = is_full(buf_lo);
  assign in_strad = in_full && (in_idx == LAST_HW);

  assign res_lo    = hw_sel(icache_res_i.blk, q_idx);
  assign res_hi    = hw_sel(icache_res_i.blk, q_idx_hi);
  assign res_full  = is_full(res_lo);
  assign res_strad = res_full && (q_idx == LAST_HW);

  // Only a response to an outstanding, non-flushed request may touch the buffer.
  assign res_fire  = req_q.valid && icache_res_i.valid && !flush_i;
  assign buf_load  = res_fire && !req_q.uncached;
  assign buf_clear = buf_inv_i || (res_fire && req_q.uncached);

  assign fetch_ready_o = (state == IDLE);
  assign icache_req_o  = req_q;
  assign unused_bits   = ^{icache_res_i.ready, fetch_pc_i[0]};

  fetch_linebuf #(
    .LINE_W  (LINE_W),
    .BLK_SIZE(BLK_SIZE),
    .HW_IDX_W(HW_IDX_W)
  ) u_linebuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_line  (req_q.addr[XLEN-1:BOFFSET]),
    .load_blk   (icache_res_i.blk),
    .lookup_line(in_line),
    .lookup_idx (in_idx),
    .hit        (buf_hit),
    .hw_lo      (buf_lo),
    .hw_hi      (buf_hi)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_q        <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_comp_o  <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      if (flush_i) begin
        state       <= IDLE;
        req_q.valid <= 1'b0;
        req_q.ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fetch_valid_i) begin
              req_q.uncached <= fetch_uncached_i;
              if (buf_hit && !in_strad) begin
                inst_valid_o <= 1'b1;
                inst_o       <= in_full ? {buf_hi, buf_lo} : {16'h0000, buf_lo};
                inst_pc_o    <= pc_in;
                inst_comp_o  <= !in_full;
              end else if (buf_hit) begin
                state       <= FETCH_HI;
                req_q.valid <= 1'b1;
                req_q.ready <= 1'b1;
                req_q.addr  <= {in_next, {BOFFSET{1'b0}}};
              end else begin
                state       <= FETCH_LO;
                req_q.valid <= 1'b1;
                req_q.ready <= 1'b1;
                req_q.addr  <= {in_line, {BOFFSET{1'b0}}};
              end
            end
          end
          FETCH_LO: begin
            if (icache_res_i.valid) begin
              if (res_strad) begin
                state      <= FETCH_HI;
                req_q.addr <= {q_next, {BOFFSET{1'b0}}};
              end else begin
                state        <= IDLE;
                req_q.valid  <= 1'b0;
                req_q.ready  <= 1'b0;
                inst_valid_o <= 1'b1;
                inst_o       <= res_full ? {res_hi, res_lo} : {16'h0000, res_lo};
                inst_pc_o    <= pc_q;
                inst_comp_o  <= !res_full;
              end
            end
          end
          FETCH_HI: begin
            if (icache_res_i.valid) begin
              state        <= IDLE;
              req_q.valid  <= 1'b0;
              req_q.ready  <= 1'b0;
              inst_valid_o <= 1'b1;
              inst_o       <= {icache_res_i.blk[15:0], saved_lo};
              inst_pc_o    <= pc_q;
              inst_comp_o  <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            req_q.valid <= 1'b0;
            req_q.ready <= 1'b0;
          end
        endcase
      end
    end
  end

  // Request PC and the low half of a straddling instruction; no reset needed.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && fetch_valid_i) begin
      pc_q     <= pc_in;
      saved_lo <= buf_lo;
    end else if (state == FETCH_LO && icache_res_i.valid) begin
      saved_lo <= icache_res_i.blk[BLK_SIZE-1 -: 16];
    end
  end

endmodule

// File: doc/fetch_align.md
# fetch_align

Fetch-side instruction aligner between the fetch PC logic and `icache`. It accepts one PC per request and issues line-aligned requests to `icache`, which returns `BLK_SIZE`-bit lines. It keeps the last cached line in a one-line buffer and extracts 16-bit (RVC) or 32-bit instructions, including 32-bit instructions that straddle two lines. The output is one aligned instruction per accepted PC, handed to decode.

## Interface
- `XLEN`, 32, address and data width
- `BLK_SIZE`, 128, cache line width in bits, must equal the `icache` line width; `BOFFSET = $clog2(BLK_SIZE/8)`, `NUM_HW = BLK_SIZE/16`
- `clk_i`  in  1  single clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `fetch_valid_i`  in  1  PC request valid
- `fetch_ready_o`  out  1  request accepted when valid && ready
- `fetch_pc_i`  in  XLEN  instruction address; bit 0 ignored (treated as 0)
- `fetch_uncached_i`  in  1  request targets an uncached region
- `flush_i`  in  1  redirect: abort in-flight request, drop pending output
- `buf_inv_i`  in  1  invalidate line buffer (fence.i)
- `icache_req_o`  out  icache_req_t  {valid, ready, addr, uncached} to `icache`
- `icache_res_i`  in  icache_res_t  {valid, ready, blk} from `icache`
- `inst_valid_o`  out  1  one-cycle pulse, instruction valid
- `inst_o`  out  32  instruction; RVC is zero-extended in [15:0]
- `inst_pc_o`  out  XLEN  PC of `inst_o`
- `inst_comp_o`  out  1  `inst_o` is compressed

## Operation
- Length rule: a halfword with bits[1:0] == 2'b11 starts a 32-bit instruction; any other value is a 16-bit instruction.
- `hw_idx = pc[BOFFSET-1:1]`, `line = pc[XLEN-1:BOFFSET]`.
- An instruction straddles when it is 32-bit and `hw_idx == NUM_HW-1`.
- `next_line = line + 1`, modulo 2^(XLEN-BOFFSET); wrap at the top of the address space is legal.
- Line buffer holds `{buf_valid, buf_line, buf_data}`. It is loaded on every `icache_res_i.valid` consumed while `uncached == 0`. An uncached response clears `buf_valid`.
- State machine has three states: IDLE, FETCH_LO and FETCH_HI.
- IDLE:
  - `fetch_ready_o = 1`.
  - On accept, if `buf_valid && line == buf_line && !straddle`, register the instruction, pulse `inst_valid_o` the next cycle and stay in IDLE (1 instruction/cycle throughput).
  - If it is a buffer hit that straddles, save the low halfword and go to FETCH_HI.
  - Otherwise, go to FETCH_LO.
- FETCH_LO:
  - `fetch_ready_o = 0`.
  - `icache_req_o = {valid=1, ready=1, addr={line,BOFFSET'0}, uncached}`, held stable until `icache_res_i.valid`.
  - On response, extract the instruction. If it does not straddle, output it and go to IDLE. If it straddles, save the low halfword (`blk[BLK_SIZE-1 -: 16]`) and go to FETCH_HI.
- FETCH_HI:
  - Request `addr = {next_line,BOFFSET'0}`.
  - On response, `inst_o = {blk[15:0], saved_lo}`, `inst_comp_o = 0`, `inst_pc_o` = original PC; go to IDLE.
- `flush_i` in any state:
  - Next state is IDLE and `icache_req_o.valid` drops the next cycle.
  - Any `icache_res_i.valid` in the flush cycle is ignored and is not written to the buffer.
  - No `inst_valid_o` is produced for the aborted PC; an instruction registered in the same cycle is suppressed.
  - The buffer contents are retained.
- `buf_inv_i` clears `buf_valid`. If it coincides with a response load, the invalidate wins.
- Outputs are registered.

## Timing
- Reset values:
  - state IDLE, `buf_valid=0`.
  - `inst_valid_o=0`, `inst_o=0`, `inst_pc_o=0`, `inst_comp_o=0`.
  - `icache_req_o=0`.
  - `fetch_ready_o=1` from the first cycle after reset.
- Reset mid-fetch returns to IDLE and drops the request the next cycle.
- Buffer hit: accept in cycle N, `inst_valid_o` in cycle N+1.
- Miss path:
  - Accept in N; `icache_req_o.valid` from N+1.
  - `icache` hit response at N+2; `inst_valid_o` at N+3.
  - On an `icache` miss, add the lower-level latency.
- Straddle adds one full `icache` round-trip.
- Request valid deasserts in the cycle after `icache_res_i.valid`. This satisfies `icache`'s `valid && !res.valid` capture.

## Structure
- Add to `tcore_param`: `fetch_align_state_e` (IDLE, FETCH_LO, FETCH_HI) and a `RVC_OPC_FULL = 2'b11` constant.
- `icache_req_t`/`icache_res_t` are reused unchanged.
- One sub-module, `fetch_linebuf`: the line register, valid bit, line-compare hit logic and halfword mux.

## Test plan
All scenarios use `BLK_SIZE=128` and an `icache` model with 1-cycle hit latency.
- Cold fetch: reset, then fetch PC 0x8000_0000 with the line word0 = 0x0000_0013. Required: `icache_req_o.addr=0x8000_0000`, then `inst_o=0x0000_0013`, `inst_comp_o=0`, `inst_valid_o` 3 cycles after accept.
- Buffer hit: next fetch PC 0x8000_0004. Required: no `icache_req_o.valid`, and `inst_valid_o` the cycle after accept with word1.
- Compressed: halfword 0x4501 at 0x8000_0008. Required: `inst_o=0x0000_4501`, `inst_comp_o=1`, `inst_pc_o=0x8000_0008`.
- Straddle: halfword 0x0513 at 0x8000_000E and halfword 0x0000 at 0x8000_0010. Required: second request addr 0x8000_0010, `inst_o=0x0000_0513`, `inst_pc_o=0x8000_000E`.
- Flush during miss: fetch 0x8000_1000 with a 10-cycle miss and `flush_i` at cycle 3. Required: req valid low the next cycle; no `inst_valid_o`; a late response is ignored; a new fetch is accepted immediately.
- Uncached and invalidate:
  - Two uncached fetches in the same line each produce an `icache` request.
  - After `buf_inv_i`, a fetch to 0x8000_0004 re-requests 0x8000_0000.
